sample_interpolator: RTL and testbench
======================================

SAMPLE_INTERPOLATOR -- requirements
Module: sample_interpolator

Interface
REQ-001 Parameter IN_BITS, default 16: sample width; matches the modulator u width.
REQ-002 Parameter LOG2_BITS, default 3: width of interp_log2; maximum 2^LOG2_BITS-1 = 7 gives 128 steps per segment.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_sample  input  IN_BITS  unsigned input sample.
REQ-006 in_valid  input  1  in_sample is offered this cycle.
REQ-007 in_ready  output  1  block accepts in_sample this cycle; transfer occurs when in_valid && in_ready.
REQ-008 interp_log2  input  LOG2_BITS  k; a segment spans 2^k advance pulses.
REQ-009 advance  input  1  consumer took u this cycle; driven by the modulator sample strobe.
REQ-010 u  output  IN_BITS  registered interpolated sample to the delta-sigma modulator.
REQ-011 underrun  output  1  sticky flag: an advance arrived with no segment to interpolate.
REQ-012 clear_underrun  input  1  clears underrun.

Function
REQ-013 A 2-entry sample FIFO shall hold accepted samples; in_ready = FIFO not full, with no combinational path from in_valid.
REQ-014 Internal registers: cur (IN_BITS), acc (IN_BITS+7 bits unsigned, 7 fraction bits), step (signed, IN_BITS+8 bits), k_lat, phase (7 bits).
REQ-015 u shall always equal acc[IN_BITS+6:7] (truncation, no rounding).
REQ-016 States: IDLE, HOLD, RUN.
REQ-017 IDLE: on FIFO non-empty, pop head into cur, set acc = cur<<7, go to HOLD; advance here is ignored and sets underrun.
REQ-018 HOLD, FIFO non-empty: pop head as nxt, latch k_lat = interp_log2, step = (nxt - cur) << (7 - k_lat), phase = 0, go to RUN; an advance in that same cycle shall not move u and shall not set underrun.
REQ-019 HOLD, FIFO empty: u held; each advance sets underrun.
REQ-020 RUN, advance with phase < 2^k_lat - 1: acc += step, phase++.
REQ-021 RUN, advance with phase = 2^k_lat - 1: acc = nxt<<7 exactly, cur = nxt, go to HOLD.
REQ-022 RUN, no advance: all state held.
REQ-023 u shall update in the cycle after the accepting advance (1-cycle latency).
REQ-024 interp_log2 changes take effect only at the next segment start.
REQ-025 k = 0 shall make each segment a single advance that jumps straight to nxt.
REQ-026 Push and pop in the same cycle on a full FIFO is not possible (in_ready = 0). On a 1-entry FIFO, simultaneous push and pop shall keep occupancy at 1.
REQ-027 When underrun set and clear_underrun occur in the same cycle, set shall win.

Reset
REQ-028 Reset shall give: state = IDLE, FIFO empty, in_ready = 1, acc = cur = step = phase = 0, u = 0, underrun = 0.
REQ-029 Reset asserted mid-segment shall discard the FIFO and the segment; the same reset values apply on the next cycle.

Structure
REQ-030 A shared package shall hold the state enum (IDLE/HOLD/RUN) and the fraction-bit constant (7).
REQ-031 The 2-entry FIFO shall be a sub-module named sample_fifo2 (valid/ready in, peek/pop out, count output).
REQ-032 No multipliers; the step shift and the accumulate shall be the only arithmetic.

Verification
REQ-033 Reset: after reset, u = 0x0000, in_ready = 1, underrun = 0; advance pulses leave u = 0 and set underrun.
REQ-034 Push 0x1000, then 0x1800, k = 2; issue 4 advances -> u = 0x1200, 0x1400, 0x1600, 0x1800, each visible 1 cycle after its advance; state ends in HOLD.
REQ-035 k = 0, samples 0x0100, 0x8000, 0x0010; advance per segment -> u jumps 0x8000, then 0x0010.
REQ-036 Push 5 samples with no advance -> first goes to cur, second starts a segment, third and fourth fill the FIFO, in_ready = 0, fifth stays pending until a segment completes.
REQ-037 Descending 0xFFFF -> 0x0000, k = 7: u is monotonic non-increasing, after 64 advances u = 0x7FFF, after 128 advances u = 0x0000 exactly.
REQ-038 Underrun: after a segment end with an empty FIFO, an advance leaves u unchanged and sets underrun = 1. clear_underrun together with another advance keeps underrun = 1; clear_underrun alone gives 0.

Source files
------------

// File: rtl/sample_interpolator_pkg.sv
// -----------------------------------------------------------------------------
// sample_interpolator_pkg
// Shared definitions for the sample interpolator slice:
//   - interp_state_e : control FSM states (IDLE / HOLD / RUN)
//   - FRAC_BITS      : fraction bits carried by the accumulator (also the
//                      phase counter width, since k never exceeds FRAC_BITS)
//   - K_W            : width of the latched segment length exponent
//   - last_phase()   : phase value on which a segment of 2^k advances ends
// -----------------------------------------------------------------------------
package sample_interpolator_pkg;

    localparam int FRAC_BITS = 7;
    localparam int K_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } interp_state_e;

    // 2^k - 1 built as a mask, so no adder or multiplier is needed.
    function automatic logic [FRAC_BITS-1:0] last_phase(input logic [K_W-1:0] k);
        logic [FRAC_BITS-1:0] ones;
        ones = {FRAC_BITS{1'b1}};
        return ~(ones << k);
    endfunction

endpackage

// File: rtl/sample_interpolator_if.sv
// -----------------------------------------------------------------------------
// sample_interpolator_if
// Sample-stream handshake plus the modulator-side advance/u pair.
//   in_sample / in_valid / in_ready : producer -> interpolator sample transfer
//   advance                         : consumer took u this cycle
//   u                               : interpolated sample to the modulator
// Modports: master = producer/consumer side, slave = interpolator.
// -----------------------------------------------------------------------------
interface sample_interpolator_if #(
    parameter int IN_BITS = 16
) ();
    logic [IN_BITS-1:0] in_sample;
    logic               in_valid;
    logic               in_ready;
    logic               advance;
    logic [IN_BITS-1:0] u;

    modport master (
        output in_sample,
        output in_valid,
        output advance,
        input  in_ready,
        input  u
    );

    modport slave (
        input  in_sample,
        input  in_valid,
        input  advance,
        output in_ready,
        output u
    );
endinterface

// File: rtl/sample_fifo2.sv
// -----------------------------------------------------------------------------
// sample_fifo2
// Two-entry FIFO for accepted input samples.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   in_data    : sample offered by the producer
//   in_valid   : in_data is offered this cycle
//   in_ready   : FIFO not full (depends on stored count only)
//   peek_data  : head entry (meaningful when count != 0)
//   pop        : consume the head this cycle (ignored when empty)
//   count      : current occupancy, 0..2
// -----------------------------------------------------------------------------
module sample_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] peek_data,
    input  logic             pop,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_r [2];
    logic             rd_ptr_r;
    logic             wr_ptr_r;
    logic [1:0]       count_r;
    logic             push_s;
    logic             pop_s;

    assign in_ready  = (count_r != 2'd2);
    assign peek_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign push_s    = in_valid && (count_r != 2'd2);
    assign pop_s     = pop && (count_r != 2'd0);

    // Storage, pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_r[0] <= {WIDTH{1'b0}};
            mem_r[1] <= {WIDTH{1'b0}};
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sample_interpolator.sv
// -----------------------------------------------------------------------------
// sample_interpolator
// Linear interpolation between consecutive input samples for a delta-sigma
// modulator. Each segment from cur to nxt spans 2^k advance pulses; u moves
// by a fixed step (7 fraction bits) per advance and lands exactly on nxt.
//   clk, reset     : clock, synchronous active-high reset
//   bus (slave)    : in_sample/in_valid/in_ready, advance, u
//   interp_log2    : k, latched at each segment start
//   clear_underrun : clears underrun (a simultaneous set wins)
//   underrun       : sticky, an advance arrived with no segment to run
// -----------------------------------------------------------------------------
module sample_interpolator
    import sample_interpolator_pkg::*;
#(
    parameter int IN_BITS   = 16,
    parameter int LOG2_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    sample_interpolator_if.slave bus,
    input  logic [LOG2_BITS-1:0] interp_log2,
    input  logic                 clear_underrun,
    output logic                 underrun
);

    localparam int ACC_W  = IN_BITS + FRAC_BITS;
    localparam int STEP_W = IN_BITS + FRAC_BITS + 1;

    interp_state_e          state_r;
    interp_state_e          state_nxt_s;

    logic [IN_BITS-1:0]     cur_r;
    logic [IN_BITS-1:0]     nxt_r;
    logic [ACC_W-1:0]       acc_r;
    logic signed [STEP_W-1:0] step_r;
    logic [K_W-1:0]         k_lat_r;
    logic [FRAC_BITS-1:0]   phase_r;
    logic                   underrun_r;

    logic [IN_BITS-1:0]     head_s;
    logic [1:0]             fifo_count_s;
    logic                   fifo_nonempty_s;
    logic                   fifo_pop_s;
    logic                   load_cur_s;
    logic                   start_seg_s;
    logic                   step_s;
    logic                   finish_s;
    logic                   underrun_set_s;
    logic                   seg_end_s;

    logic [K_W-1:0]         k_in_s;
    logic [K_W-1:0]         shift_s;
    logic signed [IN_BITS:0]  diff_s;
    logic signed [STEP_W-1:0] step_calc_s;

    sample_fifo2 #(
        .WIDTH (IN_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_data   (bus.in_sample),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .peek_data (head_s),
        .pop       (fifo_pop_s),
        .count     (fifo_count_s)
    );

    assign fifo_nonempty_s = (fifo_count_s != 2'd0);
    assign seg_end_s       = (phase_r == last_phase(k_lat_r));
    assign bus.u           = acc_r[ACC_W-1:FRAC_BITS];
    assign underrun        = underrun_r;

    // Clamp k to FRAC_BITS so the step shift never goes negative.
    always_comb begin
        if (int'(interp_log2) > FRAC_BITS) begin
            k_in_s = K_W'(FRAC_BITS);
        end else begin
            k_in_s = K_W'(interp_log2);
        end
    end

    // Per-advance step: (nxt - cur) scaled to the fraction grid, divided by 2^k.
    always_comb begin
        shift_s     = K_W'(FRAC_BITS) - k_in_s;
        diff_s      = $signed({1'b0, head_s}) - $signed({1'b0, cur_r});
        step_calc_s = {{(STEP_W-IN_BITS-1){diff_s[IN_BITS]}}, diff_s} <<< shift_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fifo_nonempty_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (fifo_nonempty_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_RUN: begin
                if (bus.advance && seg_end_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM action decode; an advance in the segment-start cycle is swallowed.
    always_comb begin
        fifo_pop_s     = 1'b0;
        load_cur_s     = 1'b0;
        start_seg_s    = 1'b0;
        step_s         = 1'b0;
        finish_s       = 1'b0;
        underrun_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                fifo_pop_s     = fifo_nonempty_s;
                load_cur_s     = fifo_nonempty_s;
                underrun_set_s = bus.advance;
            end
            ST_HOLD: begin
                if (fifo_nonempty_s) begin
                    fifo_pop_s  = 1'b1;
                    start_seg_s = 1'b1;
                end else begin
                    underrun_set_s = bus.advance;
                end
            end
            ST_RUN: begin
                if (bus.advance) begin
                    finish_s = seg_end_s;
                    step_s   = ~seg_end_s;
                end else begin
                    finish_s = 1'b0;
                    step_s   = 1'b0;
                end
            end
            default: begin
                fifo_pop_s = 1'b0;
            end
        endcase
    end

    // Datapath: segment endpoints, accumulator, step, phase and sticky underrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_r      <= {IN_BITS{1'b0}};
            nxt_r      <= {IN_BITS{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            step_r     <= {STEP_W{1'b0}};
            k_lat_r    <= {K_W{1'b0}};
            phase_r    <= {FRAC_BITS{1'b0}};
            underrun_r <= 1'b0;
        end else begin
            if (load_cur_s) begin
                cur_r <= head_s;
                acc_r <= {head_s, {FRAC_BITS{1'b0}}};
            end else if (start_seg_s) begin
                nxt_r   <= head_s;
                k_lat_r <= k_in_s;
                step_r  <= step_calc_s;
                phase_r <= {FRAC_BITS{1'b0}};
            end else if (step_s) begin
                // Two's-complement wrap in ACC_W bits is exact: the true
                // result always lies between cur and nxt.
                acc_r   <= ACC_W'({1'b0, acc_r} + $unsigned(step_r));
                phase_r <= phase_r + FRAC_BITS'(1);
            end else if (finish_s) begin
                // Land exactly on nxt regardless of accumulated truncation.
                acc_r <= {nxt_r, {FRAC_BITS{1'b0}}};
                cur_r <= nxt_r;
            end

            if (underrun_set_s) begin
                underrun_r <= 1'b1;
            end else if (clear_underrun) begin
                underrun_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_interpolator.sv
// -----------------------------------------------------------------------------
// tb_sample_interpolator
// Directed self-checking bench for sample_interpolator: reset values, k=2
// segment ramp, k=0 jumps, FIFO fill / back-pressure, k=7 descending ramp,
// underrun set/clear priority and reset in the middle of a segment.
// -----------------------------------------------------------------------------
module tb_sample_interpolator;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] interp_log2;
    logic       clear_underrun;
    logic       underrun;
    int         n_checks = 0;
    int         n_errors = 0;

    sample_interpolator_if #(.IN_BITS(16)) bus ();

    sample_interpolator #(
        .IN_BITS   (16),
        .LOG2_BITS (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .interp_log2    (interp_log2),
        .clear_underrun (clear_underrun),
        .underrun       (underrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.advance    = 1'b0;
        clear_underrun = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push(input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_sample = d;
        bus.in_valid  = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic adv_chk(input string tag, input logic [15:0] pre, input logic [15:0] post);
        @(negedge clk);
        check_eq({tag, "_pre"}, 32'(bus.u), 32'(pre));
        bus.advance = 1'b1;
        @(posedge clk);
        #1;
        bus.advance = 1'b0;
        check_eq({tag, "_post"}, 32'(bus.u), 32'(post));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] prev;
        logic [15:0] ramp_exp [4];
        int          n;
        ramp_exp[0] = 16'h1200;
        ramp_exp[1] = 16'h1400;
        ramp_exp[2] = 16'h1600;
        ramp_exp[3] = 16'h1800;

        reset          = 1'b1;
        interp_log2    = 3'd0;
        clear_underrun = 1'b0;
        bus.in_sample  = 16'h0000;
        bus.in_valid   = 1'b0;
        bus.advance    = 1'b0;

        // Reset values; advances with nothing loaded set underrun only.
        do_reset();
        @(negedge clk);
        check_eq("rst_u", 32'(bus.u), 32'h0);
        check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        adv_chk("rst_adv0", 16'h0000, 16'h0000);
        adv_chk("rst_adv1", 16'h0000, 16'h0000);
        check_eq("rst_underrun_set", 32'(underrun), 32'd1);
        @(negedge clk);
        clear_underrun = 1'b1;
        @(posedge clk);
        #1;
        clear_underrun = 1'b0;
        check_eq("rst_underrun_clr", 32'(underrun), 32'd0);

        // k=2 ramp 0x1000 -> 0x1800; advance in the segment-start cycle is ignored.
        do_reset();
        interp_log2 = 3'd2;
        push(16'h1000);
        push(16'h1800);
        adv_chk("k2_start_adv", 16'h1000, 16'h1000);
        check_eq("k2_start_no_underrun", 32'(underrun), 32'd0);
        interp_log2 = 3'd0;   // must not affect the running segment
        for (int i = 0; i < 4; i++) begin
            adv_chk("k2_ramp", (i == 0) ? 16'h1000 : ramp_exp[i-1], ramp_exp[i]);
        end
        // Segment done, FIFO empty: hold, underrun, clear priority.
        adv_chk("hold_empty", 16'h1800, 16'h1800);
        check_eq("hold_underrun", 32'(underrun), 32'd1);
        @(negedge clk);
        clear_underrun = 1'b1;
        bus.advance    = 1'b1;
        @(posedge clk);
        #1;
        clear_underrun = 1'b0;
        bus.advance    = 1'b0;
        check_eq("set_wins", 32'(underrun), 32'd1);
        check_eq("set_wins_u", 32'(bus.u), 32'h1800);
        @(negedge clk);
        clear_underrun = 1'b1;
        @(posedge clk);
        #1;
        clear_underrun = 1'b0;
        check_eq("clear_alone", 32'(underrun), 32'd0);

        // k=0: each segment is a single jump.
        do_reset();
        interp_log2 = 3'd0;
        push(16'h0100);
        push(16'h8000);
        push(16'h0010);
        idle(2);
        adv_chk("k0_jump0", 16'h0100, 16'h8000);
        idle(2);
        adv_chk("k0_jump1", 16'h8000, 16'h0010);

        // Fill: cur, segment, two in FIFO, fifth held off until a pop.
        do_reset();
        interp_log2 = 3'd0;
        push(16'h0100);
        push(16'h0200);
        push(16'h0300);
        push(16'h0400);
        @(negedge clk);
        check_eq("fill_ready_lo", 32'(bus.in_ready), 32'd0);
        check_eq("fill_u", 32'(bus.u), 32'h0100);
        bus.in_sample = 16'h0500;
        bus.in_valid  = 1'b1;
        idle(2);
        @(negedge clk);
        check_eq("fill_ready_held", 32'(bus.in_ready), 32'd0);
        adv_chk("fill_seg0", 16'h0100, 16'h0200);
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("fill_fifth_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        idle(2);
        adv_chk("fill_seg1", 16'h0200, 16'h0300);
        idle(2);
        adv_chk("fill_seg2", 16'h0300, 16'h0400);
        idle(2);
        adv_chk("fill_seg3", 16'h0400, 16'h0500);

        // k=7 descending 0xFFFF -> 0x0000.
        do_reset();
        interp_log2 = 3'd7;
        push(16'hFFFF);
        push(16'h0000);
        idle(2);
        @(negedge clk);
        check_eq("desc_start", 32'(bus.u), 32'hFFFF);
        prev = bus.u;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            bus.advance = 1'b1;
            @(posedge clk);
            #1;
            bus.advance = 1'b0;
            check_eq("desc_mono", 32'(bus.u <= prev), 32'd1);
            prev = bus.u;
            if (i == 63) begin
                check_eq("desc_half", 32'(bus.u), 32'h7FFF);
            end
        end
        check_eq("desc_end", 32'(bus.u), 32'h0000);

        // Reset mid-segment discards the FIFO and the segment.
        push(16'h4000);
        push(16'h5000);
        adv_chk("mid_step", 16'h0000, 16'h0080);
        do_reset();
        @(negedge clk);
        check_eq("mid_rst_u", 32'(bus.u), 32'h0);
        check_eq("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        check_eq("mid_rst_underrun", 32'(underrun), 32'd0);
        idle(3);
        adv_chk("mid_rst_adv", 16'h0000, 16'h0000);
        check_eq("mid_rst_underrun_set", 32'(underrun), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
